// File: rtl/pong_vga_pkg.sv
// Shared raster timing definitions for the pong display path.
// Holds the 640x480@60 Hz timing constants (used as parameter defaults by
// vga_timing_gen), the derived line/frame totals and the coordinate type.
// The draw modules use the same constants for border and paddle limits.
package pong_vga_pkg;

   localparam int COORD_W = 10;
   typedef logic [COORD_W-1:0] coord_t;

   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_FP      = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BP      = 48;
   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_FP      = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BP      = 33;
   localparam int VGA_CLK_DIV   = 4;

   localparam int H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle from vga_timing_gen to the monitor pins and draw logic.
//   hsync, vsync   : active-low sync pulses
//   video_on       : current (x,y) is inside the visible area
//   p_tick         : one-clk pixel enable
//   x, y           : current pixel column / line
//   vblank_start   : one-clk pulse on entry to (0, V_VISIBLE)
// master = timing generator, slave = consumers.
interface vga_timing_gen_if;
   import pong_vga_pkg::*;

   logic   hsync;
   logic   vsync;
   logic   video_on;
   logic   p_tick;
   coord_t x;
   coord_t y;
   logic   vblank_start;

   modport master (
      output hsync, vsync, video_on, p_tick, x, y, vblank_start
   );

   modport slave (
      input hsync, vsync, video_on, p_tick, x, y, vblank_start
   );

endinterface

// File: rtl/pixel_tick_div.sv
// Pixel enable generator: a counter running 0..CLK_DIV-1 that wraps, with a
// registered one-clk tick asserted on the edge after the counter reaches its
// last value (first tick on the CLK_DIV-th edge after reset release).
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   tick    : one clk wide, every CLK_DIV clocks
module pixel_tick_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= (div == DIV_LAST);
         div  <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel enable from pixel_tick_div, horizontal and
// vertical counters, and registered sync / visible / vblank decode.
//   clk     : system clock (100 MHz)
//   reset_n : asynchronous active-low reset
//   vga     : master side of vga_timing_gen_if (sync pins, x/y, flags)
// The decode registers are loaded from the next-state counter values, so the
// flags are always aligned with the x/y presented in the same cycle.
module vga_timing_gen
   import pong_vga_pkg::*;
#(
   parameter int H_VISIBLE = VGA_H_VISIBLE,
   parameter int H_FP      = VGA_H_FP,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BP      = VGA_H_BP,
   parameter int V_VISIBLE = VGA_V_VISIBLE,
   parameter int V_FP      = VGA_V_FP,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BP      = VGA_V_BP,
   parameter int CLK_DIV   = VGA_CLK_DIV
) (
   input  logic             clk,
   input  logic             reset_n,
   vga_timing_gen_if.master vga
);

   localparam int HT = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam coord_t H_LAST   = coord_t'(HT - 1);
   localparam coord_t V_LAST   = coord_t'(VT - 1);
   localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
   localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
   localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
   localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
   localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

   logic   p_tick;
   coord_t x_q, y_q;
   coord_t x_nxt, y_nxt;
   logic   hsync_q, vsync_q, video_on_q, vblank_q;

   pixel_tick_div #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_div (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (p_tick)
   );

   always_comb begin
      x_nxt = x_q;
      y_nxt = y_q;
      if (p_tick) begin
         if (x_q == H_LAST) begin
            x_nxt = '0;
            y_nxt = (y_q == V_LAST) ? '0 : y_q + coord_t'(1);
         end else begin
            x_nxt = x_q + coord_t'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q        <= '0;
         y_q        <= '0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         video_on_q <= 1'b0;
         vblank_q   <= 1'b0;
      end else begin
         // Gated by p_tick so the pulse lasts one clk, not the whole pixel.
         vblank_q <= p_tick && (x_nxt == '0) && (y_nxt == V_VIS);
         // Decode only moves with the counters; this keeps pixel (0,0) of
         // the first frame after reset blanked.
         if (p_tick) begin
            x_q        <= x_nxt;
            y_q        <= y_nxt;
            hsync_q    <= !((x_nxt >= HS_START) && (x_nxt < HS_END));
            vsync_q    <= !((y_nxt >= VS_START) && (y_nxt < VS_END));
            video_on_q <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
         end
      end
   end

   assign vga.p_tick       = p_tick;
   assign vga.x            = x_q;
   assign vga.y            = y_q;
   assign vga.hsync        = hsync_q;
   assign vga.vsync        = vsync_q;
   assign vga.video_on     = video_on_q;
   assign vga.vblank_start = vblank_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance (dut_a) for reset and
// line-level behaviour, and a scaled-down instance (dut_b) for frame-level,
// vblank and mid-frame reset behaviour within a short run.
module tb_vga_timing_gen;

   // scaled instance: 25 x 17 raster, 3 clocks per pixel -> 1275 clocks/frame
   localparam int B_HV = 16, B_HFP = 2, B_HS = 4, B_HBP = 3;
   localparam int B_VV = 10, B_VFP = 2, B_VS = 2, B_VBP = 3;
   localparam int B_D  = 3;
   localparam int B_HT = B_HV + B_HFP + B_HS + B_HBP;
   localparam int B_VT = B_VV + B_VFP + B_VS + B_VBP;
   localparam int B_FRAME = B_HT * B_VT * B_D;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       pt;
      logic       hs;
      logic       vs;
      logic       vo;
      logic       vb;
   } obs_t;

   typedef struct {
      int   k;
      obs_t o;
   } vec_t;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   logic run = 1'b0;
   int   k_a = 0, k_b = 0, cyc = 0;
   int   errors = 0, checks = 0;

   vga_timing_gen_if if_a ();
   vga_timing_gen_if if_b ();

   vga_timing_gen dut_a (
      .clk     (clk),
      .reset_n (rst_a),
      .vga     (if_a)
   );

   vga_timing_gen #(
      .H_VISIBLE (B_HV), .H_FP (B_HFP), .H_SYNC (B_HS), .H_BP (B_HBP),
      .V_VISIBLE (B_VV), .V_FP (B_VFP), .V_SYNC (B_VS), .V_BP (B_VBP),
      .CLK_DIV   (B_D)
   ) dut_b (
      .clk     (clk),
      .reset_n (rst_b),
      .vga     (if_b)
   );

   always #5 clk = ~clk;

   obs_t obs_a, obs_b;
   assign obs_a = {if_a.x, if_a.y, if_a.p_tick, if_a.hsync, if_a.vsync, if_a.video_on, if_a.vblank_start};
   assign obs_b = {if_b.x, if_b.y, if_b.p_tick, if_b.hsync, if_b.vsync, if_b.video_on, if_b.vblank_start};

   // k = rising edges seen since the most recent reset release
   always @(posedge clk or negedge rst_a) if (!rst_a) k_a <= 0; else k_a <= k_a + 1;
   always @(posedge clk or negedge rst_b) if (!rst_b) k_b <= 0; else k_b <= k_b + 1;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: after edge k the raster has advanced floor((k-1)/d) pixels,
   // the pixel tick is up on every d-th edge, and the flags are pure
   // functions of the resulting (x,y).
   function automatic obs_t model(int k, int d, int hv, int hfp, int hs, int hbp,
                                  int vv, int vfp, int vsy, int vbp);
      obs_t o;
      int ht, vt, adv, pos, px, py;
      ht = hv + hfp + hs + hbp;
      vt = vv + vfp + vsy + vbp;
      if (k <= 0) begin
         o = '{x: 10'd0, y: 10'd0, pt: 1'b0, hs: 1'b1, vs: 1'b1, vo: 1'b0, vb: 1'b0};
         return o;
      end
      adv  = (k - 1) / d;
      pos  = adv % (ht * vt);
      px   = pos % ht;
      py   = pos / ht;
      o.x  = 10'(px);
      o.y  = 10'(py);
      o.pt = (k % d == 0);
      o.hs = !(px >= hv + hfp && px < hv + hfp + hs);
      o.vs = !(py >= vv + vfp && py < vv + vfp + vsy);
      o.vo = (adv > 0) && (px < hv) && (py < vv);
      o.vb = (k > d) && ((k - 1) % d == 0) && (pos == vv * ht);
      return o;
   endfunction

   function automatic obs_t model_a(int k);
      return model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33);
   endfunction

   function automatic obs_t model_b(int k);
      return model(k, B_D, B_HV, B_HFP, B_HS, B_HBP, B_VV, B_VFP, B_VS, B_VBP);
   endfunction

   task automatic check(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_obs(string nm, obs_t act, obs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got x=%0d y=%0d pt=%b hs=%b vs=%b vo=%b vb=%b expected x=%0d y=%0d pt=%b hs=%b vs=%b vo=%b vb=%b (t=%0t)",
                  nm, act.x, act.y, act.pt, act.hs, act.vs, act.vo, act.vb,
                  exp.x, exp.y, exp.pt, exp.hs, exp.vs, exp.vo, exp.vb, $time);
      end
   endtask

   // continuous comparison against the reference, plus coordinate bounds
   always @(negedge clk) begin
      if (run) begin
         check_obs("cycle_a", obs_a, model_a(k_a));
         check_obs("cycle_b", obs_b, model_b(k_b));
         check("x_bound_a", int'(if_a.x <= 10'd799), 1);
         check("y_bound_a", int'(if_a.y <= 10'd524), 1);
         check("x_bound_b", int'(if_b.x <= 10'(B_HT - 1)), 1);
         check("y_bound_b", int'(if_b.y <= 10'(B_VT - 1)), 1);
      end
   end

   function automatic vec_t mk(int k, int x, int y, bit pt, bit hs, bit vs, bit vo, bit vb);
      vec_t v;
      v.k = k;
      v.o = '{x: 10'(x), y: 10'(y), pt: pt, hs: hs, vs: vs, vo: vo, vb: vb};
      return v;
   endfunction

   vec_t vecs[13];
   obs_t rst_obs;

   initial begin
      int g, cnt, t0, px, py;
      int n_hold;

      rst_obs = '{x: 10'd0, y: 10'd0, pt: 1'b0, hs: 1'b1, vs: 1'b1, vo: 1'b0, vb: 1'b0};

      // default instance, values hand-derived from the 640x480 timing
      vecs[0]  = mk(0,    0,   0, 0, 1, 1, 0, 0);
      vecs[1]  = mk(3,    0,   0, 0, 1, 1, 0, 0);
      vecs[2]  = mk(4,    0,   0, 1, 1, 1, 0, 0);
      vecs[3]  = mk(5,    1,   0, 0, 1, 1, 1, 0);
      vecs[4]  = mk(8,    1,   0, 1, 1, 1, 1, 0);
      vecs[5]  = mk(9,    2,   0, 0, 1, 1, 1, 0);
      vecs[6]  = mk(2561, 640, 0, 0, 1, 1, 0, 0);
      vecs[7]  = mk(2625, 656, 0, 0, 0, 1, 0, 0);
      vecs[8]  = mk(3005, 751, 0, 0, 0, 1, 0, 0);
      vecs[9]  = mk(3009, 752, 0, 0, 1, 1, 0, 0);
      vecs[10] = mk(3197, 799, 0, 0, 1, 1, 0, 0);
      vecs[11] = mk(3200, 799, 0, 1, 1, 1, 0, 0);
      vecs[12] = mk(3201, 0,   1, 0, 1, 1, 1, 0);

      rst_a = 1'b0;
      rst_b = 1'b0;
      #1 run = 1'b1;
      #11;                 // t=12: between a negedge and the next posedge
      rst_a = 1'b1;
      rst_b = 1'b1;
      #1;

      for (int i = 0; i < 13; i++) begin
         g = 0;
         while (k_a < vecs[i].k && g < 10000) begin
            @(negedge clk);
            g++;
         end
         check("vec_wait", k_a, vecs[i].k);
         check_obs($sformatf("vec%0d", i), obs_a, vecs[i].o);
      end

      // line 1 of the default raster: hsync low for 96 pixels = 384 clocks
      cnt = 0;
      for (int i = 0; i < 3200; i++) begin
         @(negedge clk);
         if (!if_a.hsync) cnt++;
      end
      check("hsync_low_clocks", cnt, 384);

      // vblank_start on the scaled instance
      g = 0;
      while (!if_b.vblank_start && g < 3 * B_FRAME) begin @(negedge clk); g++; end
      check("vb_seen", int'(if_b.vblank_start), 1);
      t0 = cyc;
      check("vb_x", int'(if_b.x), 0);
      check("vb_y", int'(if_b.y), B_VV);
      check("vb_video_on", int'(if_b.video_on), 0);
      @(negedge clk);
      check("vb_single_clk", int'(if_b.vblank_start), 0);
      g = 0;
      while (!if_b.vblank_start && g < 3 * B_FRAME) begin @(negedge clk); g++; end
      check("vb_period", cyc - t0, B_FRAME);

      // frame length between successive (0,0) entries
      for (int f = 0; f < 2; f++) begin
         g = 0;
         px = int'(if_b.x);
         py = int'(if_b.y);
         @(negedge clk);
         while (!(if_b.x == 0 && if_b.y == 0 && px == B_HT - 1 && py == B_VT - 1) && g < 3 * B_FRAME) begin
            px = int'(if_b.x);
            py = int'(if_b.y);
            @(negedge clk);
            g++;
         end
         check("frame_wrap_seen", int'(g < 3 * B_FRAME), 1);
         if (f == 0) t0 = cyc;
         else check("frame_period", cyc - t0, B_FRAME);
      end

      // asynchronous reset while both syncs are low
      g = 0;
      while (!(if_b.x == 10'(B_HV + B_HFP + 1) && if_b.y == 10'(B_VV + B_VFP + 1)) && g < 3 * B_FRAME) begin
         @(negedge clk);
         g++;
      end
      check("pre_rst_hsync_low", int'(if_b.hsync), 0);
      check("pre_rst_vsync_low", int'(if_b.vsync), 0);
      #($urandom_range(1, 3));
      rst_b = 1'b0;
      #1;
      check_obs("async_reset", obs_b, rst_obs);
      n_hold = $urandom_range(1, 5);
      repeat (n_hold) @(negedge clk);
      #2 rst_b = 1'b1;
      #1;
      check_obs("release_k0", obs_b, rst_obs);
      g = 0;
      while (k_b < B_D && g < 100) begin @(negedge clk); g++; end
      check_obs("release_first_tick", obs_b,
                '{x: 10'd0, y: 10'd0, pt: 1'b1, hs: 1'b1, vs: 1'b1, vo: 1'b0, vb: 1'b0});
      @(negedge clk);
      check_obs("release_first_advance", obs_b,
                '{x: 10'd1, y: 10'd0, pt: 1'b0, hs: 1'b1, vs: 1'b1, vo: 1'b1, vb: 1'b0});

      // random-time resets; the continuous check covers the restart
      for (int r = 0; r < 4; r++) begin
         repeat ($urandom_range(50, 1500)) @(negedge clk);
         #($urandom_range(1, 4));
         rst_b = 1'b0;
         #1;
         check_obs("rand_reset", obs_b, rst_obs);
         @(negedge clk);
         #1 rst_b = 1'b1;
      end

      repeat (2000) @(negedge clk);
      run = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
